byte_queue: RTL and testbench
=============================

# byte_queue

Synchronous byte FIFO that sits directly downstream of the serial-to-parallel deserializer. It captures each completed byte through the deserializer's `data_ready`/`ack_in` handshake and buffers up to `DEPTH` bytes. It presents the oldest byte to the consumer, which pops it with a one-cycle dequeue strobe. Single clock domain on `clock_100k`.

## Interface
- `DEPTH`, 8, number of byte slots; power of two, ≥2
- `WIDTH`, 8, data width in bits
- `clock_100k`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `data_in`  in  WIDTH  byte from deserializer; valid and stable while `data_ready_in`=1
- `data_ready_in`  in  1  deserializer has a complete byte waiting
- `ack_out`  out  1  one-cycle pulse to deserializer `ack_in`: byte has been stored
- `deq_in`  in  1  consumer pops head entry on this edge
- `data_out`  out  WIDTH  head entry; forced to 0 when empty
- `len_out`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- `empty_out`  out  1  `len_out`==0
- `full_out`  out  1  `len_out`==DEPTH
- `underflow_out`  out  1  sticky: set by `deq_in` while empty; cleared only by reset

## Operation
- Storage: DEPTH×WIDTH array, write pointer `wr_ptr`, read pointer `rd_ptr`, each $clog2(DEPTH) bits. Pointers wrap modulo DEPTH with natural overflow. Occupancy is held in a separate counter `len`.
- Enqueue FSM, three states:
  - IDLE: if `data_ready_in`=1 and `len`<DEPTH, write `data_in` at `wr_ptr`, increment `wr_ptr`, set `ack_out`=1, go to ACK. Otherwise stay; `ack_out`=0.
  - ACK: `ack_out`=0; go to DRAIN. This gives exactly one cycle high.
  - DRAIN: wait for `data_ready_in`=0, then go to IDLE. Prevents a second capture of the same byte while the deserializer is still deasserting.
- Dequeue: on an edge with `deq_in`=1 and `len`>0, increment `rd_ptr`. `deq_in`=1 with `len`=0 changes no pointer and sets `underflow_out`.
- `len` update per edge: +1 on enqueue only, −1 on dequeue only, unchanged when both or neither occur.
- Full: the enqueue decision uses `len` sampled before the edge. If the queue is full and a dequeue frees a slot on the same edge, the pending byte is not accepted on that edge. It is accepted on the next edge while `data_ready_in` remains 1. No byte is ever dropped or overwritten.
- `data_out` = `mem[rd_ptr]` combinationally when `len`>0, else 0. `len_out`, `empty_out` and `full_out` are derived combinationally from `len`.
- Reset (asynchronous, any time including mid-handshake):
  - state=IDLE, `wr_ptr`=`rd_ptr`=`len`=0, `ack_out`=0, `underflow_out`=0.
  - Memory contents are not cleared; they are unobservable because `data_out`=0 when empty.
  - Reset values: `data_out`=0, `len_out`=0, `empty_out`=1, `full_out`=0.

## Timing
- Enqueue latency: `data_ready_in` seen high at edge N (IDLE, not full) → byte stored and `ack_out`=1 after N → `ack_out`=0 after N+1.
- The deserializer samples `ack_in` at N+1 and drops `data_ready` after N+1. The queue returns to IDLE at N+2 at the earliest.
- Back-to-back enqueues are at least 3 cycles apart, well within 8 serial bit times.
- `len_out` and `data_out` reflect an enqueue after edge N, and a dequeue after the edge that samples `deq_in`.
- First-word-fall-through: a byte stored into an empty queue is visible on `data_out` after edge N.
- `ack_out` is never high for two consecutive cycles and is never asserted while `full_out`=1 before the edge.

## Test plan
- Reset then single enqueue of 8'hA5: `ack_out` high exactly one cycle; then `data_out`=A5, `len_out`=1, `empty_out`=0. `deq_in` pulse → `len_out`=0, `data_out`=0.
- Enqueue 8'h01..8'h08: `full_out`=1, `len_out`=8. Present 8'h09: no `ack_out` while full. One `deq_in` → `data_out`=01 popped; 09 acked on the following edge; drain order 02..09.
- Wrap-around: 20 bytes streamed with interleaved single pops keeping `len_out`≤3. Output order equals input order and no byte is duplicated.
- Simultaneous enqueue and dequeue with `len_out`=4: `len_out` stays 4 and the head advances.
- `deq_in` while empty: `underflow_out`=1 and stays 1 through later traffic; pointers unchanged.
- Reset asserted in ACK state with 3 entries stored: outputs return to reset values immediately. After release, `data_ready_in` still high is accepted once as a fresh byte.

Source files
------------

// File: rtl/byte_queue.sv
// byte_queue: byte FIFO fed by the deserializer's data_ready/ack handshake, first-word-fall-through output.
module byte_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clock_100k,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     data_ready_in,
  output logic                     ack_out,
  input  logic                     deq_in,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   len_out,
  output logic                     empty_out,
  output logic                     full_out,
  output logic                     underflow_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {IDLE, ACK, DRAIN} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_len;
  logic r_underflow;
  logic w_full, w_empty, w_enq, w_deq;
  assign w_full  = r_len == LW'(DEPTH);
  assign w_empty = r_len == '0;
  // Capture decision uses pre-edge occupancy, so a same-edge pop never admits a byte into a full queue.
  assign w_enq = (r_state == IDLE) && data_ready_in && !w_full;
  assign w_deq = deq_in && !w_empty;
  always_comb begin
    w_next = (r_state == IDLE) ? (w_enq ? ACK : IDLE) :
             (r_state == ACK)  ? DRAIN :
             (data_ready_in ? DRAIN : IDLE);
  end
  always_ff @(posedge clock_100k or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_len       <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_enq) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_enq && !w_deq) r_len <= r_len + LW'(1);
      else if (w_deq && !w_enq) r_len <= r_len - LW'(1);
      if (deq_in && w_empty) r_underflow <= 1'b1;
    end
  end
  always_ff @(posedge clock_100k) begin
    if (w_enq && !reset) r_mem[r_wr_ptr] <= data_in;
  end
  assign ack_out       = r_state == ACK;
  assign data_out      = w_empty ? '0 : r_mem[r_rd_ptr];
  assign len_out       = r_len;
  assign empty_out     = w_empty;
  assign full_out      = w_full;
  assign underflow_out = r_underflow;
endmodule

// File: tb/tb_byte_queue.sv
// tb_byte_queue: scoreboard-driven bench for byte_queue with a deserializer-style producer and a strobe consumer.
module tb_byte_queue;
  logic       clock_100k = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_ready_in;
  logic       ack_out;
  logic       deq_in;
  logic [7:0] data_out;
  logic [3:0] len_out;
  logic       empty_out;
  logic       full_out;
  logic       underflow_out;
  logic [7:0] sb[$];
  int checks = 0;
  int fails  = 0;

  byte_queue #(.DEPTH(8), .WIDTH(8)) dut (
    .clock_100k(clock_100k), .reset(reset), .data_in(data_in),
    .data_ready_in(data_ready_in), .ack_out(ack_out), .deq_in(deq_in),
    .data_out(data_out), .len_out(len_out), .empty_out(empty_out),
    .full_out(full_out), .underflow_out(underflow_out)
  );

  always #5 clock_100k = ~clock_100k;

  task automatic step();
    @(posedge clock_100k);
    #1;
  endtask

  // Deserializer model: hold the byte until acked, drop ready the cycle after the ack.
  task automatic send(input logic [7:0] b);
    int n = 0;
    data_in = b;
    data_ready_in = 1'b1;
    do begin step(); n++; end while (!ack_out && n < 20);
    checks++;
    if (ack_out !== 1'b1) begin
      fails++;
      $display("FAIL send_ack byte=%h: ack_out=%b required 1 within 20 cycles", b, ack_out);
    end else sb.push_back(b);
    step();
    checks++;
    if (ack_out !== 1'b0) begin
      fails++;
      $display("FAIL ack_one_cycle byte=%h: ack_out=%b required 0", b, ack_out);
    end
    data_ready_in = 1'b0;
    step();
  endtask

  task automatic pop();
    logic [7:0] exp;
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL pop_sb_empty: data_out=%h required no pending entry", data_out);
    end else begin
      exp = sb.pop_front();
      if (data_out !== exp) begin
        fails++;
        $display("FAIL pop_data: data_out=%h required %h", data_out, exp);
      end
    end
    deq_in = 1'b1;
    step();
    deq_in = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({ack_out, data_out, len_out, empty_out, full_out, underflow_out} !== {1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_values: ack=%b data=%h len=%0d empty=%b full=%b uf=%b required 0 00 0 1 0 0",
               ack_out, data_out, len_out, empty_out, full_out, underflow_out);
    end
  endtask

  task automatic test_single();
    send(8'hA5);
    checks++;
    if (data_out !== 8'hA5 || len_out !== 4'd1 || empty_out !== 1'b0) begin
      fails++;
      $display("FAIL single_enq: data=%h len=%0d empty=%b required a5 1 0", data_out, len_out, empty_out);
    end
    pop();
    checks++;
    if (len_out !== 4'd0 || data_out !== 8'h00 || empty_out !== 1'b1) begin
      fails++;
      $display("FAIL single_deq: data=%h len=%0d empty=%b required 00 0 1", data_out, len_out, empty_out);
    end
  endtask

  task automatic test_full();
    for (int i = 1; i <= 8; i++) send(8'(i));
    checks++;
    if (full_out !== 1'b1 || len_out !== 4'd8) begin
      fails++;
      $display("FAIL full_flag: full=%b len=%0d required 1 8", full_out, len_out);
    end
    data_in = 8'h09;
    data_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ack_out !== 1'b0) begin
        fails++;
        $display("FAIL ack_while_full: ack_out=%b required 0", ack_out);
      end
    end
    pop();
    checks++;
    if (ack_out !== 1'b0 || len_out !== 4'd7) begin
      fails++;
      $display("FAIL full_pop_edge: ack=%b len=%0d required 0 7", ack_out, len_out);
    end
    step();
    checks++;
    if (ack_out !== 1'b1 || len_out !== 4'd8) begin
      fails++;
      $display("FAIL full_late_accept: ack=%b len=%0d required 1 8", ack_out, len_out);
    end else sb.push_back(8'h09);
    step();
    data_ready_in = 1'b0;
    step();
    for (int i = 0; i < 8; i++) pop();
    checks++;
    if (empty_out !== 1'b1 || len_out !== 4'd0) begin
      fails++;
      $display("FAIL full_drain: empty=%b len=%0d required 1 0", empty_out, len_out);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      send(8'h30 + 8'(i * 7));
      if (len_out == 4'd3) pop();
      checks++;
      if (len_out > 4'd3 || len_out !== 4'(sb.size())) begin
        fails++;
        $display("FAIL wrap_len: len_out=%0d required %0d (<=3)", len_out, sb.size());
      end
    end
    while (sb.size() != 0) pop();
    checks++;
    if (empty_out !== 1'b1) begin
      fails++;
      $display("FAIL wrap_drain: empty=%b required 1", empty_out);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) send(8'h41 + 8'(i));
    data_in = 8'h45;
    data_ready_in = 1'b1;
    pop();
    sb.push_back(8'h45);
    checks++;
    if (ack_out !== 1'b1 || len_out !== 4'd4 || data_out !== sb[0]) begin
      fails++;
      $display("FAIL simul_enq_deq: ack=%b len=%0d data=%h required 1 4 %h", ack_out, len_out, data_out, sb[0]);
    end
    step();
    data_ready_in = 1'b0;
    step();
    while (sb.size() != 0) pop();
  endtask

  task automatic test_underflow();
    deq_in = 1'b1;
    step();
    deq_in = 1'b0;
    checks++;
    if (underflow_out !== 1'b1 || len_out !== 4'd0 || data_out !== 8'h00) begin
      fails++;
      $display("FAIL underflow_set: uf=%b len=%0d data=%h required 1 0 00", underflow_out, len_out, data_out);
    end
    send(8'h5A);
    send(8'h6B);
    pop();
    pop();
    checks++;
    if (underflow_out !== 1'b1 || len_out !== 4'd0) begin
      fails++;
      $display("FAIL underflow_sticky: uf=%b len=%0d required 1 0", underflow_out, len_out);
    end
  endtask

  task automatic test_reset_mid_ack();
    int n = 0;
    for (int i = 0; i < 3; i++) send(8'h90 + 8'(i));
    data_in = 8'hC3;
    data_ready_in = 1'b1;
    do begin step(); n++; end while (!ack_out && n < 20);
    reset = 1'b1;
    #1;
    sb.delete();
    checks++;
    if ({ack_out, data_out, len_out, empty_out, full_out, underflow_out} !== {1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid_ack: ack=%b data=%h len=%0d empty=%b full=%b uf=%b required 0 00 0 1 0 0",
               ack_out, data_out, len_out, empty_out, full_out, underflow_out);
    end
    step();
    step();
    reset = 1'b0;
    n = 0;
    do begin step(); n++; end while (!ack_out && n < 20);
    checks++;
    if (ack_out !== 1'b1 || data_out !== 8'hC3 || len_out !== 4'd1) begin
      fails++;
      $display("FAIL post_reset_accept: ack=%b data=%h len=%0d required 1 c3 1", ack_out, data_out, len_out);
    end else sb.push_back(8'hC3);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ack_out !== 1'b0 || len_out !== 4'd1) begin
        fails++;
        $display("FAIL post_reset_once: ack=%b len=%0d required 0 1", ack_out, len_out);
      end
    end
    data_ready_in = 1'b0;
    step();
    pop();
    checks++;
    if (len_out !== 4'd0) begin
      fails++;
      $display("FAIL post_reset_drain: len=%0d required 0", len_out);
    end
  endtask

  initial begin
    reset = 1'b1;
    data_in = 8'h00;
    data_ready_in = 1'b0;
    deq_in = 1'b0;
    step();
    test_reset();
    step();
    reset = 1'b0;
    step();
    test_reset();
    test_single();
    test_full();
    test_wrap();
    test_simultaneous();
    test_underflow();
    test_reset_mid_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
